xlnx_startup_seq: RTL and testbench

Parametrised successor to the PCIe/USB2 bring-up selector. It sequences up to NMODES candidate link interfaces sharing one pipe MMCM. Mode 0 is passive: it is probed for lock without driving resets. Modes 1..NMODES-1 are active: each runs a clock-enable / PHY-release / MMCM-reset / lock-wait / logic-reset sequence. The block adds bounded lock retries, fallback to the next enabled mode with wrap-around, and failure reporting. It sits at the top of the board's clocking logic, on the free-running configuration clock.

---
 rtl/xlnx_startup_seq_pkg.sv | 21 ++
 rtl/xlnx_startup_seq_next_mode.sv | 30 +++
 rtl/xlnx_startup_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_xlnx_startup_seq.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xlnx_startup_seq_pkg.sv
// Shared definitions for the link bring-up sequencer.
// State encodings are fixed 4-bit values exported on debug_state.
package xlnx_startup_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    PROBE     = 4'd1,
    CLK_EN    = 4'd2,
    PHY_REL   = 4'd3,
    MMCM_RST  = 4'd4,
    MMCM_REL  = 4'd5,
    WAIT_LOCK = 4'd6,
    LOGIC_H   = 4'd7,
    LOGIC_L   = 4'd8,
    DONE      = 4'd9,
    NEXT      = 4'd10
  } state_e;

  localparam int LOCK_LOSS_LEN = 16;

endpackage

// File: rtl/xlnx_startup_seq_next_mode.sv
// Finds the lowest enabled mode and the next enabled mode above cur.
// wrap_o is set when no enabled mode lies above cur.
module xlnx_startup_next_mode #(
  parameter int NMODES = 2,
  parameter int IW     = 1
) (
  input  logic [NMODES-1:0] en_i,
  input  logic [IW-1:0]     cur_i,
  output logic [IW-1:0]     first_o,
  output logic [IW-1:0]     next_o,
  output logic              wrap_o
);

  always_comb begin
    first_o = '0;
    next_o  = '0;
    wrap_o  = 1'b1;
    for (int i = NMODES - 1; i >= 0; i--) begin
      if (en_i[i]) begin
        first_o = IW'(i);
        if (i > int'(cur_i)) begin
          next_o = IW'(i);
          wrap_o = 1'b0;
        end
      end
    end
    if (wrap_o) next_o = first_o;
  end

endmodule

// File: rtl/xlnx_startup_seq.sv
// Multi-mode link bring-up sequencer on the configuration clock.
// Define STARTUP_LOCK_MONITOR_EN to restart on lock loss in DONE.
module xlnx_startup_seq
  import xlnx_startup_pkg::*;
#(
  parameter int NMODES     = 2,
  parameter int PROBE_BITS = 28,
  parameter int STEP_BITS  = 8,
  parameter int LOCK_STEPS = 4,
  parameter int MAX_RETRY  = 3
) (
  input  logic              cfg_mclk,
  input  logic              cfg_rst,
  input  logic [NMODES-1:0] mode_en,
  input  logic [NMODES-1:0] clk_ready,
  input  logic              mmcm_lock,
  output logic [NMODES-1:0] mode_sel,
  output logic              mmcm_rst_n,
  output logic [NMODES-1:0] phy_clk_en,
  output logic [NMODES-1:0] phy_nrst,
  output logic              logic_reset,
  output logic              user_reset,
  output logic              done,
  output logic              fail,
  output logic [3:0]        retry_cnt,
  output logic [3:0]        debug_state
);

  localparam int IW  = (NMODES > 1) ? $clog2(NMODES) : 1;
  localparam int LW  = $clog2(LOCK_STEPS) + 1;
  localparam int CW0 = (PROBE_BITS > STEP_BITS + LW) ?
                       PROBE_BITS : STEP_BITS + LW;
  localparam int CW  = (CW0 < 5) ? 5 : CW0;

  localparam logic [CW-1:0] PROBE_LAST =
    CW'((64'd1 << PROBE_BITS) - 64'd1);
  localparam logic [CW-1:0] STEP_LAST =
    CW'((64'd1 << STEP_BITS) - 64'd1);
  localparam logic [CW-1:0] WAIT_LAST =
    CW'(64'(LOCK_STEPS) * (64'd1 << STEP_BITS) - 64'd1);
`ifdef STARTUP_LOCK_MONITOR_EN
  localparam logic [CW-1:0] LOSS_LAST = CW'(LOCK_LOSS_LEN - 1);
`endif

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     mode_q, mode_d;
  logic [NMODES-1:0] en_q, en_d;
  logic [NMODES-1:0] sel_q, sel_d;
  logic [NMODES-1:0] clk_en_q, clk_en_d;
  logic [NMODES-1:0] nrst_q, nrst_d;
  logic              mrst_n_q, mrst_n_d;
  logic              lrst_q, lrst_d;
  logic              urst_q, urst_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [3:0]        retry_q, retry_d;
  logic              lock_meta_q, lock_sync_q;

  logic [NMODES-1:0] search_en;
  logic [IW-1:0]     first_m, next_m, tgt;
  logic              wrap, launch;

  assign search_en = (state_q == IDLE) ? mode_en : en_q;

  xlnx_startup_next_mode #(
    .NMODES (NMODES),
    .IW     (IW)
  ) u_next (
    .en_i    (search_en),
    .cur_i   (mode_q),
    .first_o (first_m),
    .next_o  (next_m),
    .wrap_o  (wrap)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    mode_d   = mode_q;
    en_d     = en_q;
    sel_d    = sel_q;
    clk_en_d = clk_en_q;
    nrst_d   = nrst_q;
    mrst_n_d = mrst_n_q;
    lrst_d   = lrst_q;
    urst_d   = urst_q;
    done_d   = done_q;
    fail_d   = fail_q;
    retry_d  = retry_q;
    launch   = 1'b0;
    tgt      = first_m;
    case (state_q)
      IDLE: begin
        en_d = mode_en;
        if (mode_en == '0) fail_d = 1'b1;
        else launch = 1'b1;
      end
      PROBE: begin
        if (cnt_q == PROBE_LAST) begin
          if (lock_sync_q) begin
            urst_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = NEXT;
          end
        end
      end
      CLK_EN: begin
        // no timeout: a dead reference clock parks the FSM here
        if (cnt_q == '0 && !clk_ready[mode_q]) cnt_d = '0;
        if (cnt_q == STEP_LAST) begin
          nrst_d[mode_q] = 1'b1;
          state_d        = PHY_REL;
        end
      end
      PHY_REL: begin
        if (cnt_q == STEP_LAST) begin
          mrst_n_d = 1'b0;
          state_d  = MMCM_RST;
        end
      end
      MMCM_RST: begin
        if (cnt_q == STEP_LAST) begin
          mrst_n_d = 1'b1;
          state_d  = MMCM_REL;
        end
      end
      MMCM_REL: begin
        if (cnt_q == STEP_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (cnt_q == WAIT_LAST) begin
          if (lock_sync_q) begin
            state_d = LOGIC_H;
          end else begin
            retry_d = retry_q + 4'd1;
            if (retry_d >= 4'(MAX_RETRY)) begin
              state_d = NEXT;
            end else begin
              mrst_n_d = 1'b0;
              state_d  = MMCM_RST;
            end
          end
        end
      end
      LOGIC_H: begin
        lrst_d = 1'b1;
        if (cnt_q == STEP_LAST) begin
          lrst_d  = 1'b0;
          urst_d  = 1'b0;
          state_d = LOGIC_L;
        end
      end
      LOGIC_L: begin
        done_d  = 1'b1;
        state_d = DONE;
      end
      NEXT: begin
        sel_d    = '0;
        clk_en_d = '0;
        nrst_d   = '0;
        retry_d  = '0;
        tgt      = next_m;
        launch   = 1'b1;
        if (wrap) fail_d = 1'b1;
      end
      DONE: begin
`ifdef STARTUP_LOCK_MONITOR_EN
        if (lock_sync_q) begin
          cnt_d = '0;
        end else if (cnt_q == LOSS_LAST) begin
          done_d  = 1'b0;
          urst_d  = 1'b1;
          lrst_d  = 1'b1;
          retry_d = '0;
          if (mode_q == '0) begin
            state_d = PROBE;
          end else begin
            mrst_n_d = 1'b0;
            state_d  = MMCM_RST;
          end
        end
`else
        cnt_d = cnt_q;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      mode_d = tgt;
      sel_d  = NMODES'(1) << tgt;
      if (tgt == '0) begin
        state_d = PROBE;
      end else begin
        clk_en_d[tgt] = 1'b1;
        state_d       = CLK_EN;
      end
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge cfg_mclk) begin
    lock_meta_q <= mmcm_lock;
    lock_sync_q <= lock_meta_q;
    if (cfg_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mode_q   <= '0;
      en_q     <= '0;
      sel_q    <= '0;
      clk_en_q <= '0;
      nrst_q   <= '0;
      mrst_n_q <= 1'b1;
      lrst_q   <= 1'b1;
      urst_q   <= 1'b1;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      en_q     <= en_d;
      sel_q    <= sel_d;
      clk_en_q <= clk_en_d;
      nrst_q   <= nrst_d;
      mrst_n_q <= mrst_n_d;
      lrst_q   <= lrst_d;
      urst_q   <= urst_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      retry_q  <= retry_d;
    end
  end

  assign mode_sel    = sel_q;
  assign mmcm_rst_n  = mrst_n_q;
  assign phy_clk_en  = clk_en_q;
  assign phy_nrst    = nrst_q;
  assign logic_reset = lrst_q;
  assign user_reset  = urst_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign retry_cnt   = retry_q;
  assign debug_state = state_q;

endmodule

// File: tb/tb_xlnx_startup_seq.sv
// Randomised bench for xlnx_startup_seq with a timeline model.
// Expected times are derived from step/window lengths and lock latency.
module tb_xlnx_startup_seq;

  localparam int NM = 3;
  localparam int PB = 6;
  localparam int SB = 2;
  localparam int LS = 4;
  localparam int MR = 2;
  localparam int P  = 1 << PB;
  localparam int S  = 1 << SB;
  localparam int W  = LS * S;

  logic          clk = 1'b0;
  logic          cfg_rst;
  logic [NM-1:0] mode_en;
  logic [NM-1:0] clk_ready;
  logic          mmcm_lock;
  logic [NM-1:0] mode_sel, phy_clk_en, phy_nrst;
  logic          mmcm_rst_n, logic_reset, user_reset, done, fail;
  logic [3:0]    retry_cnt, debug_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int low_run, npulse, bad_pulse;
  int done_rise, done_fall, lr_fall, ur_fall, fail_rise;
  logic done_p, lr_p, ur_p, fail_p;

  always #5 clk = ~clk;

  xlnx_startup_seq #(
    .NMODES     (NM),
    .PROBE_BITS (PB),
    .STEP_BITS  (SB),
    .LOCK_STEPS (LS),
    .MAX_RETRY  (MR)
  ) dut (
    .cfg_mclk    (clk),
    .cfg_rst     (cfg_rst),
    .mode_en     (mode_en),
    .clk_ready   (clk_ready),
    .mmcm_lock   (mmcm_lock),
    .mode_sel    (mode_sel),
    .mmcm_rst_n  (mmcm_rst_n),
    .phy_clk_en  (phy_clk_en),
    .phy_nrst    (phy_nrst),
    .logic_reset (logic_reset),
    .user_reset  (user_reset),
    .done        (done),
    .fail        (fail),
    .retry_cnt   (retry_cnt),
    .debug_state (debug_state)
  );

  localparam logic [21:0] RST_VEC =
    {3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0};

  function automatic logic [21:0] out_vec();
    return {mode_sel, mmcm_rst_n, phy_clk_en, phy_nrst, logic_reset,
            user_reset, done, fail, retry_cnt, debug_state};
  endfunction

  task automatic clear_obs();
    low_run = 0; npulse = 0; bad_pulse = 0;
    done_rise = -1; done_fall = -1; lr_fall = -1;
    ur_fall = -1; fail_rise = -1;
    done_p = done; lr_p = logic_reset; ur_p = user_reset; fail_p = fail;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (!mmcm_rst_n) low_run++;
    else if (low_run > 0) begin
      npulse++;
      if (low_run != S) bad_pulse++;
      low_run = 0;
    end
    if (done && !done_p && done_rise < 0) done_rise = cyc;
    if (!done && done_p && done_fall < 0) done_fall = cyc;
    if (!logic_reset && lr_p && lr_fall < 0) lr_fall = cyc;
    if (!user_reset && ur_p && ur_fall < 0) ur_fall = cyc;
    if (fail && !fail_p && fail_rise < 0) fail_rise = cyc;
    done_p = done; lr_p = logic_reset; ur_p = user_reset; fail_p = fail;
  endtask

  task automatic do_reset();
    cfg_rst = 1'b1;
    mmcm_lock = 1'b0;
    tick();
    tick();
    cfg_rst = 1'b0;
    cyc = 0;
    clear_obs();
  endtask

  task automatic test_reset();
    int exp_st;
    mode_en = NM'($urandom_range(1, 7));
    clk_ready = '0;
    do_reset();
    checks++;
    if (out_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL reset_vals got %h want %h", out_vec(), RST_VEC);
    end
    exp_st = mode_en[0] ? 1 : 2;
    tick();
    checks++;
    if (debug_state !== 4'(exp_st)) begin
      errors++;
      $display("FAIL idle_exit got %0d want %0d", debug_state, exp_st);
    end
  endtask

  task automatic test_empty();
    mode_en = '0;
    do_reset();
    repeat (3) tick();
    checks++;
    if (fail !== 1'b1 || debug_state !== 4'd0 || mode_sel !== 3'b000) begin
      errors++;
      $display("FAIL empty_mask fail=%b st=%0d sel=%b want 1 0 000",
               fail, debug_state, mode_sel);
    end
  endtask

  // lock driven after edge e is seen by the FSM at edge e+3
  task automatic test_probe_lock();
    int e;
    bit hit;
    for (int it = 0; it < 4; it++) begin
      e = (it == 0) ? P - 2 : (it == 1) ? P - 1 : $urandom_range(0, P - 3);
      hit = (e + 3 <= 1 + P);
      mode_en = 3'b111;
      clk_ready = 3'b111;
      do_reset();
      while (cyc < P + 2) begin
        if (cyc == e) mmcm_lock = 1'b1;
        tick();
      end
      checks++;
      if (hit) begin
        if (done_rise !== 1 + P || mode_sel !== 3'b001 ||
            phy_clk_en !== 3'b000 || npulse + low_run != 0 ||
            user_reset !== 1'b0) begin
          errors++;
          $display("FAIL probe_lock e=%0d rise=%0d sel=%b en=%b p=%0d ur=%b want %0d 001 000 0 0",
                   e, done_rise, mode_sel, phy_clk_en, npulse, user_reset, 1 + P);
        end
      end else begin
        if (done_rise != -1 || debug_state !== 4'd2 || mode_sel !== 3'b010) begin
          errors++;
          $display("FAIL probe_late e=%0d rise=%0d st=%0d sel=%b want -1 2 010",
                   e, done_rise, debug_state, mode_sel);
        end
      end
    end
  endtask

  task automatic test_probe_drop();
    int a, b;
    a = $urandom_range(5, 20);
    b = $urandom_range(a + 5, P - 10);
    mode_en = 3'b111;
    clk_ready = 3'b111;
    do_reset();
    while (cyc < P + 2) begin
      if (cyc == a) mmcm_lock = 1'b1;
      if (cyc == b) mmcm_lock = 1'b0;
      tick();
    end
    checks++;
    if (done_rise != -1 || debug_state !== 4'd2 || phy_clk_en !== 3'b010) begin
      errors++;
      $display("FAIL probe_drop rise=%0d st=%0d en=%b want -1 2 010",
               done_rise, debug_state, phy_clk_en);
    end
  endtask

  task automatic test_active_lock();
    int t_clk, t_rel, t_end, t_done, e;
    for (int it = 0; it < 3; it++) begin
      mode_en = {1'($urandom), 1'b1, 1'($urandom)};
      clk_ready = {1'($urandom), 1'b1, 1'($urandom)};
      t_clk = mode_en[0] ? P + 2 : 1;
      t_rel = t_clk + 3 * S;
      t_end = t_rel + S + W;
      t_done = t_end + S + 1;
      e = (it == 0) ? t_rel + 2 : $urandom_range(t_rel, t_end - 3);
      do_reset();
      while (cyc < t_done + 3) begin
        if (cyc == e) mmcm_lock = 1'b1;
        tick();
      end
      checks++;
      if (done_rise != t_done || mode_sel !== 3'b010 ||
          phy_clk_en !== 3'b010 || phy_nrst !== 3'b010) begin
        errors++;
        $display("FAIL active_done en=%b rise=%0d sel=%b ce=%b nr=%b want %0d 010 010 010",
                 mode_en, done_rise, mode_sel, phy_clk_en, phy_nrst, t_done);
      end
      checks++;
      if (npulse != 1 || bad_pulse != 0) begin
        errors++;
        $display("FAIL active_pulse n=%0d bad=%0d want 1 0", npulse, bad_pulse);
      end
      checks++;
      if (lr_fall != t_end + S || ur_fall != t_end + S ||
          fail !== 1'b0 || debug_state !== 4'd9) begin
        errors++;
        $display("FAIL active_rst lr=%0d ur=%0d fail=%b st=%0d want %0d %0d 0 9",
                 lr_fall, ur_fall, fail, debug_state, t_end + S, t_end + S);
      end
    end
  endtask

  task automatic test_no_lock();
    int t, np, first;
    logic [NM-1:0] exp_sel, exp_ce;
    for (int it = 0; it < 3; it++) begin
      mode_en = (it == 0) ? 3'b111 : NM'($urandom_range(1, 7));
      clk_ready = 3'b111;
      t = 1;
      for (int i = 0; i < NM; i++)
        if (mode_en[i])
          t += (i == 0) ? P + 1 : 2 * S + MR * (2 * S + W) + 1;
      np = MR * $countones(mode_en[2:1]);
      first = mode_en[0] ? 0 : mode_en[1] ? 1 : 2;
      exp_sel = 3'b001 << first;
      exp_ce = (first == 0) ? 3'b000 : exp_sel;
      do_reset();
      while (cyc < t) tick();
      checks++;
      if (fail_rise != t || npulse != np || bad_pulse != 0) begin
        errors++;
        $display("FAIL nolock_fail en=%b rise=%0d n=%0d bad=%0d want %0d %0d 0",
                 mode_en, fail_rise, npulse, bad_pulse, t, np);
      end
      checks++;
      if (debug_state !== 4'((first == 0) ? 1 : 2) || mode_sel !== exp_sel ||
          phy_clk_en !== exp_ce || retry_cnt !== 4'd0) begin
        errors++;
        $display("FAIL nolock_wrap st=%0d sel=%b ce=%b rc=%0d want sel %b ce %b",
                 debug_state, mode_sel, phy_clk_en, retry_cnt, exp_sel, exp_ce);
      end
    end
  endtask

  task automatic test_clk_stall();
    int n, bad;
    for (int it = 0; it < 2; it++) begin
      n = (it == 0) ? 100 : $urandom_range(20, 99);
      bad = 0;
      mode_en = 3'b100;
      clk_ready = 3'b000;
      do_reset();
      while (cyc < n) begin
        tick();
        if (debug_state !== 4'd2 || phy_clk_en !== 3'b100) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL stall_hold n=%0d bad_cycles=%0d want 0", n, bad);
      end
      clk_ready = 3'b100;
      repeat (S - 1) tick();
      checks++;
      if (debug_state !== 4'd2) begin
        errors++;
        $display("FAIL stall_early st=%0d want 2", debug_state);
      end
      tick();
      checks++;
      if (debug_state !== 4'd3 || phy_nrst !== 3'b100) begin
        errors++;
        $display("FAIL stall_go st=%0d nr=%b want 3 100", debug_state, phy_nrst);
      end
    end
  endtask

  task automatic test_rst_mid();
    int t_w2, r;
    t_w2 = 1 + 4 * S + W + 2 * S;
    r = $urandom_range(t_w2 + 1, t_w2 + W - 1);
    mode_en = 3'b010;
    clk_ready = 3'b010;
    do_reset();
    while (cyc < r) tick();
    checks++;
    if (debug_state !== 4'd6 || retry_cnt !== 4'd1) begin
      errors++;
      $display("FAIL mid_wait st=%0d rc=%0d want 6 1", debug_state, retry_cnt);
    end
    cfg_rst = 1'b1;
    tick();
    cfg_rst = 1'b0;
    checks++;
    if (out_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL mid_reset got %h want %h", out_vec(), RST_VEC);
    end
  endtask

  task automatic reach_done();
    mode_en = 3'b010;
    clk_ready = 3'b010;
    do_reset();
    while (cyc < 45) begin
      if (cyc == 1 + 3 * S + 1) mmcm_lock = 1'b1;
      tick();
    end
    checks++;
    if (done_rise != 1 + 4 * S + W + S + 1) begin
      errors++;
      $display("FAIL mon_reach rise=%0d want %0d", done_rise,
               1 + 4 * S + W + S + 1);
    end
    clear_obs();
  endtask

`ifdef STARTUP_LOCK_MONITOR_EN
  task automatic test_lock_monitor();
    reach_done();
    mmcm_lock = 1'b0;
    repeat (15) tick();
    mmcm_lock = 1'b1;
    while (cyc < 80) tick();
    checks++;
    if (done_fall != -1 || done !== 1'b1) begin
      errors++;
      $display("FAIL mon_short fall=%0d done=%b want -1 1", done_fall, done);
    end
    mmcm_lock = 1'b0;
    while (cyc < 99) tick();
    checks++;
    if (done_fall != 98 || user_reset !== 1'b1 || logic_reset !== 1'b1 ||
        mmcm_rst_n !== 1'b0 || retry_cnt !== 4'd0 || debug_state !== 4'd4) begin
      errors++;
      $display("FAIL mon_loss fall=%0d ur=%b lr=%b mr=%b rc=%0d st=%0d want 98 1 1 0 0 4",
               done_fall, user_reset, logic_reset, mmcm_rst_n, retry_cnt, debug_state);
    end
  endtask
`else
  task automatic test_done_hold();
    reach_done();
    mmcm_lock = 1'b0;
    repeat (40) tick();
    checks++;
    if (done_fall != -1 || done !== 1'b1 || debug_state !== 4'd9) begin
      errors++;
      $display("FAIL done_hold fall=%0d done=%b st=%0d want -1 1 9",
               done_fall, done, debug_state);
    end
  endtask
`endif

  initial begin
    cfg_rst = 1'b1;
    mode_en = '0;
    clk_ready = '0;
    mmcm_lock = 1'b0;
    test_reset();
    test_empty();
    test_probe_lock();
    test_probe_drop();
    test_active_lock();
    test_no_lock();
    test_clk_stall();
    test_rst_mid();
`ifdef STARTUP_LOCK_MONITOR_EN
    test_lock_monitor();
`else
    test_done_hold();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
